// File: rtl/divisor_freq_prog_pkg.sv
// Shared types and constants for the programmable frequency divider.
// Mode encoding, reference clock rate and channel-index width helper.
package divisor_freq_prog_pkg;

    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_SQUARE = 1'b1
    } mode_t;

    localparam int CLK_HZ = 50_000_000;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/divisor_freq_prog_if.sv
// Control/status bundle of the programmable divider.
// The master drives enables and configuration writes; the slave returns outputs.
interface divisor_freq_prog_if
    import divisor_freq_prog_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 26
);
    localparam int CH_W = ch_width(NUM_CH);

    logic              en;
    logic              sync;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [CNT_W-1:0]  wr_div;
    logic              wr_mode;
    logic              wr_err;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] f_out;

    modport master (
        output en, sync, wr_en, wr_ch, wr_div, wr_mode,
        input  wr_err, tick, f_out
    );

    modport slave (
        input  en, sync, wr_en, wr_ch, wr_div, wr_mode,
        output wr_err, tick, f_out
    );

endinterface

// File: rtl/divisor_freq_prog_canal.sv
// One divider channel: counter, divisor and mode with registered tick/f_out.
// Priority: reset, load, clear, halt (D=0), enable.
module divisor_freq_prog_canal
    import divisor_freq_prog_pkg::*;
#(
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 50000
) (
    input  logic             f_in,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_div,
    input  mode_t            ld_mode,
    output logic             tick,
    output logic             f_out
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    mode_t            mode;
    logic             wrap;

    assign wrap = (cnt == div - CNT_W'(1));

    always_ff @(posedge f_in) begin
        if (reset) begin
            cnt   <= '0;
            div   <= CNT_W'(DEFAULT_DIV);
            mode  <= MODE_PULSE;
            tick  <= 1'b0;
            f_out <= 1'b0;
        end else if (ld) begin
            div   <= ld_div;
            mode  <= ld_mode;
            cnt   <= '0;
            tick  <= 1'b0;
            f_out <= 1'b0;
        end else if (clr || div == '0) begin
            cnt   <= '0;
            tick  <= 1'b0;
            f_out <= 1'b0;
        end else if (!en) begin
            tick  <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            tick  <= (mode == MODE_PULSE);
            // In pulse mode f_out stays at the 0 it was cleared to on load
            if (mode == MODE_SQUARE) f_out <= ~f_out;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/divisor_freq_prog.sv
// Runtime-programmable multi-channel frequency divider.
// Decodes channel writes, broadcasts sync and flags out-of-range writes.
module divisor_freq_prog
    import divisor_freq_prog_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 50000
) (
    input logic               f_in,
    input logic               reset,
    divisor_freq_prog_if.slave bus
);

    localparam int CH_W = ch_width(NUM_CH);

    logic valid;

    assign valid = (32'(bus.wr_ch) < 32'(NUM_CH));

    always_ff @(posedge f_in) begin
        if (reset) begin
            bus.wr_err <= 1'b0;
        end else begin
            bus.wr_err <= bus.wr_en && !valid;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ld;

        assign ld = bus.wr_en && (bus.wr_ch == CH_W'(i));

        divisor_freq_prog_canal #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_canal (
            .f_in    (f_in),
            .reset   (reset),
            .en      (bus.en),
            .clr     (bus.sync),
            .ld      (ld),
            .ld_div  (bus.wr_div),
            .ld_mode (mode_t'(bus.wr_mode)),
            .tick    (bus.tick[i]),
            .f_out   (bus.f_out[i])
        );
    end

endmodule
